// File: rtl/ring_arbiter.sv
// 16-way round-robin arbiter with a one-hot rotating priority pointer and registered grant.
// Optional forced release after MAX_HOLD cycles when RING_ARB_TIMEOUT_EN is defined.
module ring_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [0:15] REQ,
    input  logic        DONE,
    output logic [0:15] GNT,
    output logic [3:0]  GNT_IDX,
    output logic        GNT_VALID,
    output logic        TIMEOUT
);
    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  ptr, ptr_nxt;
    logic [0:N-1]  gnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic          valid_nxt;
    logic          timeout_nxt;
    logic [IW-1:0] ptr_idx;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;
    logic          rel;
    logic          tmo_hit;

`ifdef RING_ARB_TIMEOUT_EN
    logic [3:0] cnt, cnt_nxt;

    // Forced release only when the owner would otherwise keep the resource
    assign tmo_hit = (state == HOLD) && (cnt == 4'(MAX_HOLD - 1)) && !DONE && REQ[GNT_IDX];

    always_comb begin
        cnt_nxt = '0;
        if (state == HOLD && !rel) begin
            cnt_nxt = cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^4'(MAX_HOLD);
    assign tmo_hit    = 1'b0;
`endif

    // Winner search: first set request at or after the pointer, wrapping 15 -> 0
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (ptr[i]) begin
                ptr_idx = ptr_idx | IW'(i);
            end
        end
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int off = 0; off < int'(N); off++) begin
            cand = ptr_idx + IW'(off);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = GNT;
        idx_nxt     = GNT_IDX;
        valid_nxt   = GNT_VALID;
        timeout_nxt = 1'b0;
        rel         = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    idx_nxt      = win;
                    valid_nxt    = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                rel = DONE || !REQ[GNT_IDX] || tmo_hit;
                if (rel) begin
                    gnt_nxt     = '0;
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    state_nxt   = IDLE;
                    ptr_nxt     = N'(1) << (GNT_IDX + 4'd1);
                    timeout_nxt = tmo_hit;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= N'(1);
            GNT       <= '0;
            GNT_IDX   <= '0;
            GNT_VALID <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            GNT       <= gnt_nxt;
            GNT_IDX   <= idx_nxt;
            GNT_VALID <= valid_nxt;
            TIMEOUT   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed self-checking bench for ring_arbiter; expected values are hand-derived.
module tb_ring_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [0:15] req;
    logic        done;
    logic [0:15] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    ring_arbiter #(.MAX_HOLD(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ       (req),
        .DONE      (done),
        .GNT       (gnt),
        .GNT_IDX   (gnt_idx),
        .GNT_VALID (gnt_valid),
        .TIMEOUT   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [0:15] oh(input int i);
        logic [0:15] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input int i);
        chk(tag, 16'(gnt), 16'(oh(i)));
        chk(tag, 16'(gnt_idx), 16'(i));
        chk(tag, 16'(gnt_valid), 16'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 16'(gnt), 16'h0000);
        chk(tag, 16'(gnt_idx), 16'd0);
        chk(tag, 16'(gnt_valid), 16'd0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '1;
        done = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_timeout", 16'(timeout), 16'd0);

        // First grant after reset goes to 0; then full rotation with DONE always high
        rst = 1'b0;
        tick();
        chk_grant("first_grant", 0);
        done = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk_idle("rot_gap");
            tick();
            chk_grant("rot_grant", i % 16);
            chk("rot_onehot", 16'($onehot0(gnt)), 16'd1);
        end
        req  = '0;
        done = 1'b0;
        tick();
        chk_idle("rot_end");

        // Single requester 5 held three cycles, then DONE; PTR=6 picks 7 over 4
        req = oh(5);
        tick();
        chk_grant("single5", 5);
        tick();
        tick();
        chk_grant("single5_hold", 5);
        done = 1'b1;
        tick();
        chk_idle("single5_rel");
        done = 1'b0;
        req  = oh(4) | oh(7);
        tick();
        chk_grant("ptr6_pick7", 7);
        done = 1'b1;
        tick();
        chk_idle("rel7");

        // Wrap-around: serve 13, then 15 before 3, then 3, then 15 again (PTR=4)
        done = 1'b0;
        req  = oh(13);
        tick();
        chk_grant("serve13", 13);
        done = 1'b1;
        tick();
        chk_idle("rel13");
        done = 1'b0;
        req  = oh(3) | oh(15);
        tick();
        chk_grant("wrap15", 15);
        done = 1'b1;
        tick();
        chk_idle("rel15");
        tick();
        chk_grant("wrap3", 3);
        tick();
        chk_idle("rel3");
        tick();
        chk_grant("ptr4_pick15", 15);
        tick();
        chk_idle("rel15b");
        req  = '0;
        done = 1'b0;
        tick();
        chk_idle("quiet");

        // Owner drop: 9 released by deasserting its request; PTR=10 picks 10 over 9
        req = oh(9);
        tick();
        chk_grant("own9", 9);
        req = '0;
        tick();
        chk_idle("drop9");
        chk("drop9_timeout", 16'(timeout), 16'd0);
        req = oh(9) | oh(10);
        tick();
        chk_grant("ptr10_pick10", 10);
        done = 1'b1;
        tick();
        chk_idle("rel10");
        done = 1'b0;
        req  = '0;
        tick();

        // Long hold of requester 2 with requester 3 waiting
        req = oh(2) | oh(3);
        tick();
        chk_grant("hold2", 2);
`ifdef RING_ARB_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            tick();
            chk_grant("hold2_cyc", 2);
            chk("hold2_no_tmo", 16'(timeout), 16'd0);
        end
        tick();
        chk_idle("tmo_rel");
        chk("tmo_pulse", 16'(timeout), 16'd1);
        tick();
        chk_grant("ptr3_pick3", 3);
        chk("tmo_cleared", 16'(timeout), 16'd0);
`else
        for (int c = 1; c < 100; c++) begin
            tick();
            chk_grant("hold2_cyc", 2);
            chk("hold2_no_tmo", 16'(timeout), 16'd0);
        end
`endif
        // Reset mid-hold clears the grant and PTR returns to 0
        rst = 1'b1;
        tick();
        chk_idle("rst_midhold");
        chk("rst_midhold_tmo", 16'(timeout), 16'd0);
        rst = 1'b0;
        req = '1;
        tick();
        chk_grant("post_rst_grant", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
